daq_frame_tx: RTL

// - DAQ frame transmitter; sits directly upstream of the CRC-32 generator.
// - Takes a 16-bit payload stream, frames it as HDR | payload | CRC_HI | CRC_LO | TRL.
// - Drives the generator's init/calc/d_valid/d strobes and consumes its 16-bit crc output.
// - Inserts that crc output as the two CRC words of each frame. Feeds the serializer link.

---
 rtl/daq_frame_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/daq_frame_tx.sv
// daq_frame_tx -- DAQ frame transmitter feeding a serializer link.
//
// Frames a 16-bit payload stream as HDR | payload... | CRC_HI | CRC_LO | TRL.
// The external CRC-32 generator is driven through crc_init/crc_calc/crc_dv/crc_d.
// Its 16-bit crc_in output is inserted as the two CRC words. crc_in shows
// the high half after the last calc and the low half after one shift strobe.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready   payload stream in (valid/ready)
//   crc_d/crc_calc/crc_init/crc_dv  strobes to the CRC generator
//   crc_in                      generator output, updates 1 clk after crc_dv
//   m_data/m_k/m_valid/m_ready  link word out; m_k=1 marks HDR/TRL control words
//   frame_err                   sticky: a frame was truncated at MAX_WORDS
//
// Configuration macro DAQ_LEN_TRAILER_EN: when defined, the trailer carries
// {4'hE, payload count} instead of TRL_WORD.
module daq_frame_tx #(
  parameter logic [15:0] HDR_WORD  = 16'hB0C5,
  parameter logic [15:0] TRL_WORD  = 16'hE0F5,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] crc_d,
  output logic        crc_calc,
  output logic        crc_init,
  output logic        crc_dv,
  input  logic [15:0] crc_in,
  output logic [15:0] m_data,
  output logic        m_k,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC_HI, CRC_LO, TRL} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        m_data_q;
  logic               m_k_q;
  logic               m_valid_q;
  logic               crc_init_q;
  logic               frame_err_q;

  logic               adv;
  logic               accept;
  logic               at_max;
  logic [15:0]        trl_word;

  // The output register can take a new word when empty or being drained.
  assign adv    = ~m_valid_q | m_ready;
  assign accept = (state_q == DATA) & s_valid & adv;
  assign at_max = (cnt_q == CNT_W'(MAX_WORDS - 1));

`ifdef DAQ_LEN_TRAILER_EN
  // Control nibble is the one shared with the fixed trailer (4'hE).
  assign trl_word = {TRL_WORD[15:12], 12'(cnt_q)};
`else
  assign trl_word = TRL_WORD;
`endif

  // Generator strobes are combinational so they land on the same edge that
  // loads the corresponding word into the output register.
  always_comb begin
    s_ready  = (state_q == DATA) & adv;
    crc_calc = accept;
    crc_dv   = accept | ((state_q == CRC_HI) & adv);
    crc_d    = accept ? s_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      m_data_q    <= '0;
      m_k_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      crc_init_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      crc_init_q <= 1'b0;
      // Any load below overrides this clear.
      if (m_ready) m_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid && adv) begin
            crc_init_q <= 1'b1;
            state_q    <= HDR;
          end
        end
        HDR: begin
          if (adv) begin
            m_data_q  <= HDR_WORD;
            m_k_q     <= 1'b1;
            m_valid_q <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            m_data_q  <= s_data;
            m_k_q     <= 1'b0;
            m_valid_q <= 1'b1;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (s_last || at_max) begin
              state_q <= CRC_HI;
              if (!s_last) frame_err_q <= 1'b1;
            end
          end
        end
        CRC_HI: begin
          if (adv) begin
            m_data_q  <= crc_in;
            m_k_q     <= 1'b0;
            m_valid_q <= 1'b1;
            state_q   <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (adv) begin
            m_data_q  <= crc_in;
            m_k_q     <= 1'b0;
            m_valid_q <= 1'b1;
            state_q   <= TRL;
          end
        end
        TRL: begin
          if (adv) begin
            m_data_q  <= trl_word;
            m_k_q     <= 1'b1;
            m_valid_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_k       = m_k_q;
  assign m_valid   = m_valid_q;
  assign crc_init  = crc_init_q;
  assign frame_err = frame_err_q;

endmodule
